// File: rtl/tcp_vlg_opt_parse_if.sv
// Parsed-option payload types and the byte-stream/result interface for tcp_vlg_opt_parse.
// The package is kept here so the payload type travels with the interface that carries it.
package tcp_vlg_opt_parse_pkg;

  localparam int unsigned MAX_SACK          = 4;
  localparam int unsigned TCP_MAX_WIN_SCALE = 14;
  localparam int unsigned OPT_LEN_W         = 6;
  localparam int unsigned BYTE_W            = 8;

  typedef struct packed {
    logic        mss_pres;
    logic [15:0] mss;
  } tcp_opt_mss_t;

  typedef struct packed {
    logic       wnd_pres;
    logic [3:0] wnd;
  } tcp_opt_wnd_t;

  typedef struct packed {
    logic sack_perm_pres;
    logic sack_perm;
  } tcp_opt_sack_perm_t;

  // Block arrays are ascending so that block_pres reads block 0 first.
  typedef struct packed {
    logic                           sack_pres;
    logic [0:MAX_SACK-1]            block_pres;
    logic [0:MAX_SACK-1][31:0]      left;
    logic [0:MAX_SACK-1][31:0]      right;
  } tcp_opt_sack_t;

  typedef struct packed {
    logic        timestamp_pres;
    logic [31:0] snd;
    logic [31:0] rec;
  } tcp_opt_timestamp_t;

  typedef struct packed {
    logic mss_pres;
    logic wnd_pres;
    logic sack_perm_pres;
    logic sack_pres;
    logic timestamp_pres;
  } tcp_opt_pres_t;

  typedef struct packed {
    tcp_opt_mss_t       tcp_opt_mss;
    tcp_opt_wnd_t       tcp_opt_wnd;
    tcp_opt_sack_perm_t tcp_opt_sack_perm;
    tcp_opt_sack_t      tcp_opt_sack;
    tcp_opt_timestamp_t tcp_opt_timestamp;
    tcp_opt_pres_t      tcp_opt_pres;
  } tcp_opt_t;

endpackage

interface tcp_vlg_opt_parse_if;
  import tcp_vlg_opt_parse_pkg::*;

  logic                 hdr_val;
  logic [OPT_LEN_W-1:0] opt_len;
  logic [BYTE_W-1:0]    rx_dat;
  logic                 rx_val;
  tcp_opt_t             opt;
  logic                 opt_val;
  logic                 opt_err;

  modport master (
    output hdr_val, opt_len, rx_dat, rx_val,
    input  opt, opt_val, opt_err
  );

  modport slave (
    input  hdr_val, opt_len, rx_dat, rx_val,
    output opt, opt_val, opt_err
  );

endinterface

// File: rtl/tcp_vlg_opt_parse.sv
// TCP options parser: walks the option byte stream after the fixed header and
// captures MSS, window scale, SACK-permitted, SACK blocks and timestamps.
module tcp_vlg_opt_parse
  import tcp_vlg_opt_parse_pkg::*;
#(
  parameter int unsigned SACK_BLOCKS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tcp_vlg_opt_parse_if.slave   bus
);

  localparam int unsigned CNT_W   = 6;
  localparam int unsigned STAGE_W = 64;

  typedef enum logic [2:0] {
    IDLE,
    KIND,
    LEN,
    DATA,
    SKIP,
    DONE
  } state_e;

  state_e                            state_q, state_d;
  logic [OPT_LEN_W-1:0]              remaining_q, remaining_d;
  logic [BYTE_W-1:0]                 kind_q, kind_d;
  logic [CNT_W-1:0]                  dlen_q, dlen_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic                              apply_q, apply_d;
  logic [MAX_SACK-1:0][STAGE_W-1:0]  stage_q, stage_d;
  tcp_opt_t                          opt_q, opt_d;
  logic                              opt_val_q, opt_val_d;
  logic                              opt_err_q, opt_err_d;

  logic [OPT_LEN_W-1:0]              rem_after;
  logic                              last_byte;
  logic                              accept;
  logic                              commit;
  logic [2:0]                        nblk;
  logic [BYTE_W-1:0]                 wnd_byte;

  function automatic logic kind_known(input logic [BYTE_W-1:0] k);
    return (k == 8'd2) || (k == 8'd3) || (k == 8'd4) || (k == 8'd5) || (k == 8'd8);
  endfunction

  // Length rule for known kinds; unknown kinds accept any length >= 2.
  function automatic logic len_legal(input logic [BYTE_W-1:0] k, input logic [BYTE_W-1:0] l);
    case (k)
      8'd2:    return l == 8'd4;
      8'd3:    return l == 8'd3;
      8'd4:    return l == 8'd2;
      8'd5:    return (l >= 8'd10) && (l <= 8'd34) && (l[2:0] == 3'd2);
      8'd8:    return l == 8'd10;
      default: return 1'b1;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    kind_d      = kind_q;
    dlen_d      = dlen_q;
    cnt_d       = cnt_q;
    apply_d     = apply_q;
    stage_d     = stage_q;
    opt_d       = opt_q;
    opt_err_d   = opt_err_q;
    commit      = 1'b0;
    nblk        = 3'd0;
    wnd_byte    = 8'd0;

    rem_after = remaining_q - 6'd1;
    last_byte = (rem_after == 6'd0);
    accept    = bus.rx_val && ((state_q == KIND) || (state_q == LEN) ||
                               (state_q == DATA) || (state_q == SKIP));

    if (bus.hdr_val) begin
      opt_d       = tcp_opt_t'('0);
      opt_err_d   = 1'b0;
      remaining_d = bus.opt_len;
      kind_d      = 8'd0;
      dlen_d      = 6'd0;
      cnt_d       = 6'd0;
      apply_d     = 1'b0;
      state_d     = (bus.opt_len == 6'd0) ? DONE : KIND;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end else if (accept) begin
      remaining_d = rem_after;
      unique case (state_q)
        KIND: begin
          if (bus.rx_dat == 8'd0) begin
            state_d = last_byte ? DONE : SKIP;
          end else if (bus.rx_dat == 8'd1) begin
            state_d = last_byte ? DONE : KIND;
          end else begin
            kind_d  = bus.rx_dat;
            state_d = last_byte ? DONE : LEN;
          end
        end
        LEN: begin
          // Reject lengths that cannot fit in the bytes still owed by the segment.
          if ((bus.rx_dat < 8'd2) || ((bus.rx_dat - 8'd2) > {2'b00, rem_after})) begin
            opt_err_d = 1'b1;
            state_d   = last_byte ? DONE : SKIP;
          end else begin
            apply_d = kind_known(kind_q) && len_legal(kind_q, bus.rx_dat);
            if (kind_known(kind_q) && !len_legal(kind_q, bus.rx_dat)) begin
              opt_err_d = 1'b1;
            end
            dlen_d = 6'(bus.rx_dat - 8'd2);
            cnt_d  = 6'd0;
            if (bus.rx_dat == 8'd2) begin
              commit  = apply_d;
              state_d = last_byte ? DONE : KIND;
            end else begin
              state_d = DATA;
            end
          end
        end
        DATA: begin
          if (cnt_q < 6'd32) begin
            stage_d[cnt_q[4:3]][{3'd7 - cnt_q[2:0], 3'b000} +: 8] = bus.rx_dat;
          end
          cnt_d  = cnt_q + 6'd1;
          dlen_d = dlen_q - 6'd1;
          if (dlen_q == 6'd1) begin
            commit  = apply_q;
            state_d = last_byte ? DONE : KIND;
          end else if (last_byte) begin
            opt_err_d = 1'b1;
            state_d   = DONE;
          end
        end
        SKIP: begin
          if (last_byte) begin
            state_d = DONE;
          end
        end
        default: ;
      endcase
    end

    // Staged bytes become visible only once the whole option has arrived.
    if (commit) begin
      nblk     = cnt_d[5:3];
      wnd_byte = stage_d[0][63:56];
      case (kind_q)
        8'd2: begin
          opt_d.tcp_opt_mss.mss          = stage_d[0][63:48];
          opt_d.tcp_opt_mss.mss_pres     = 1'b1;
          opt_d.tcp_opt_pres.mss_pres    = 1'b1;
        end
        8'd3: begin
          opt_d.tcp_opt_wnd.wnd          = (wnd_byte > 8'(TCP_MAX_WIN_SCALE)) ?
                                           4'(TCP_MAX_WIN_SCALE) : wnd_byte[3:0];
          opt_d.tcp_opt_wnd.wnd_pres     = 1'b1;
          opt_d.tcp_opt_pres.wnd_pres    = 1'b1;
        end
        8'd4: begin
          opt_d.tcp_opt_sack_perm.sack_perm      = 1'b1;
          opt_d.tcp_opt_sack_perm.sack_perm_pres = 1'b1;
          opt_d.tcp_opt_pres.sack_perm_pres      = 1'b1;
        end
        8'd5: begin
          for (int unsigned i = 0; i < MAX_SACK; i++) begin
            if ((i < 32'(nblk)) && (i < SACK_BLOCKS)) begin
              opt_d.tcp_opt_sack.block_pres[i] = 1'b1;
              opt_d.tcp_opt_sack.left[i]       = stage_d[i][63:32];
              opt_d.tcp_opt_sack.right[i]      = stage_d[i][31:0];
            end else begin
              opt_d.tcp_opt_sack.block_pres[i] = 1'b0;
              opt_d.tcp_opt_sack.left[i]       = 32'd0;
              opt_d.tcp_opt_sack.right[i]      = 32'd0;
            end
          end
          opt_d.tcp_opt_sack.sack_pres   = 1'b1;
          opt_d.tcp_opt_pres.sack_pres   = 1'b1;
        end
        8'd8: begin
          opt_d.tcp_opt_timestamp.snd            = stage_d[0][63:32];
          opt_d.tcp_opt_timestamp.rec            = stage_d[0][31:0];
          opt_d.tcp_opt_timestamp.timestamp_pres = 1'b1;
          opt_d.tcp_opt_pres.timestamp_pres      = 1'b1;
        end
        default: ;
      endcase
    end

    opt_val_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      remaining_q <= 6'd0;
      kind_q      <= 8'd0;
      dlen_q      <= 6'd0;
      cnt_q       <= 6'd0;
      apply_q     <= 1'b0;
      stage_q     <= '0;
      opt_q       <= tcp_opt_t'('0);
      opt_val_q   <= 1'b0;
      opt_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      kind_q      <= kind_d;
      dlen_q      <= dlen_d;
      cnt_q       <= cnt_d;
      apply_q     <= apply_d;
      stage_q     <= stage_d;
      opt_q       <= opt_d;
      opt_val_q   <= opt_val_d;
      opt_err_q   <= opt_err_d;
    end
  end

  assign bus.opt     = opt_q;
  assign bus.opt_val = opt_val_q;
  assign bus.opt_err = opt_err_q;

endmodule

// File: tb/tb_tcp_vlg_opt_parse.sv
// Directed bench for tcp_vlg_opt_parse: hand-built option segments with expected results.
module tb_tcp_vlg_opt_parse;
  import tcp_vlg_opt_parse_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  logic [7:0] seg[$];
  tcp_opt_t   exp_opt;

  tcp_vlg_opt_parse_if bus_if ();

  tcp_vlg_opt_parse #(.SACK_BLOCKS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_opt(input string tag, input tcp_opt_t obs, input tcp_opt_t exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hdr(input logic [5:0] len);
    bus_if.hdr_val = 1'b1;
    bus_if.opt_len = len;
    bus_if.rx_val  = 1'b0;
    tick();
    bus_if.hdr_val = 1'b0;
  endtask

  // Streams seg[]; optional idle gap before byte stall_at; checks opt_val timing.
  task automatic send(input string tag, input int stall_at, input int stall_n, input bit final_done);
    for (int i = 0; i < seg.size(); i++) begin
      if (i == stall_at) begin
        for (int s = 0; s < stall_n; s++) begin
          bus_if.rx_val = 1'b0;
          bus_if.rx_dat = 8'hEE;
          tick();
          check({tag, "_stall_val"}, 64'(bus_if.opt_val), 64'd0);
        end
      end
      bus_if.rx_val = 1'b1;
      bus_if.rx_dat = seg[i];
      tick();
      if ((i == seg.size() - 1) && final_done)
        check({tag, "_val"}, 64'(bus_if.opt_val), 64'd1);
      else
        check({tag, "_early_val"}, 64'(bus_if.opt_val), 64'd0);
    end
    bus_if.rx_val = 1'b0;
  endtask

  initial begin
    rst_n          = 1'b0;
    bus_if.hdr_val = 1'b0;
    bus_if.opt_len = 6'd0;
    bus_if.rx_dat  = 8'd0;
    bus_if.rx_val  = 1'b0;
    repeat (2) tick();
    check_opt("rst_opt", bus_if.opt, tcp_opt_t'('0));
    check("rst_val", 64'(bus_if.opt_val), 64'd0);
    check("rst_err", 64'(bus_if.opt_err), 64'd0);
    rst_n = 1'b1;
    tick();

    // Empty option area completes one cycle after hdr_val.
    hdr(6'd0);
    check("empty_val", 64'(bus_if.opt_val), 64'd1);
    check_opt("empty_opt", bus_if.opt, tcp_opt_t'('0));
    check("empty_err", 64'(bus_if.opt_err), 64'd0);
    tick();
    check("empty_val_pulse", 64'(bus_if.opt_val), 64'd0);

    // SYN: MSS, NOP, window scale, SACK permitted, END padding.
    seg = '{8'h02, 8'h04, 8'h05, 8'hB4, 8'h01, 8'h03, 8'h03, 8'h07, 8'h04, 8'h02, 8'h00, 8'h00};
    hdr(6'd12);
    send("syn", -1, 0, 1'b1);
    exp_opt = '0;
    exp_opt.tcp_opt_mss.mss                  = 16'h05B4;
    exp_opt.tcp_opt_mss.mss_pres             = 1'b1;
    exp_opt.tcp_opt_wnd.wnd                  = 4'd7;
    exp_opt.tcp_opt_wnd.wnd_pres             = 1'b1;
    exp_opt.tcp_opt_sack_perm.sack_perm      = 1'b1;
    exp_opt.tcp_opt_sack_perm.sack_perm_pres = 1'b1;
    exp_opt.tcp_opt_pres.mss_pres            = 1'b1;
    exp_opt.tcp_opt_pres.wnd_pres            = 1'b1;
    exp_opt.tcp_opt_pres.sack_perm_pres      = 1'b1;
    check_opt("syn_opt", bus_if.opt, exp_opt);
    check("syn_err", 64'(bus_if.opt_err), 64'd0);
    tick();
    check("syn_val_pulse", 64'(bus_if.opt_val), 64'd0);
    check_opt("syn_opt_hold", bus_if.opt, exp_opt);

    // Timestamp with a 3-cycle rx_val gap mid-stream.
    seg = '{8'h01, 8'h01, 8'h08, 8'h0A, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    hdr(6'd12);
    send("ts", 8, 3, 1'b1);
    exp_opt = '0;
    exp_opt.tcp_opt_timestamp.snd            = 32'h11223344;
    exp_opt.tcp_opt_timestamp.rec            = 32'h55667788;
    exp_opt.tcp_opt_timestamp.timestamp_pres = 1'b1;
    exp_opt.tcp_opt_pres.timestamp_pres      = 1'b1;
    check_opt("ts_opt", bus_if.opt, exp_opt);
    check("ts_err", 64'(bus_if.opt_err), 64'd0);

    // Two SACK blocks.
    seg = '{8'h01, 8'h01, 8'h05, 8'h12,
            8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00,
            8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00};
    hdr(6'd20);
    send("sack", -1, 0, 1'b1);
    exp_opt = '0;
    exp_opt.tcp_opt_sack.block_pres = 4'b1100;
    exp_opt.tcp_opt_sack.left[0]    = 32'h00000100;
    exp_opt.tcp_opt_sack.right[0]   = 32'h00000200;
    exp_opt.tcp_opt_sack.left[1]    = 32'h00000300;
    exp_opt.tcp_opt_sack.right[1]   = 32'h00000400;
    exp_opt.tcp_opt_sack.sack_pres  = 1'b1;
    exp_opt.tcp_opt_pres.sack_pres  = 1'b1;
    check_opt("sack_opt", bus_if.opt, exp_opt);
    check("sack_block_pres", 64'(bus_if.opt.tcp_opt_sack.block_pres), 64'hC);
    check("sack_err", 64'(bus_if.opt_err), 64'd0);

    // Window scale with wrong length is flagged and not applied.
    seg = '{8'h03, 8'h04, 8'h0E, 8'h00};
    hdr(6'd4);
    send("wnd_badlen", -1, 0, 1'b1);
    check("wnd_badlen_err", 64'(bus_if.opt_err), 64'd1);
    check("wnd_badlen_pres", 64'(bus_if.opt.tcp_opt_wnd.wnd_pres), 64'd0);
    check_opt("wnd_badlen_opt", bus_if.opt, tcp_opt_t'('0));

    // Window scale above the maximum is clamped to 14.
    seg = '{8'h03, 8'h03, 8'h20, 8'h00};
    hdr(6'd4);
    send("wnd_clamp", -1, 0, 1'b1);
    check("wnd_clamp_wnd", 64'(bus_if.opt.tcp_opt_wnd.wnd), 64'd14);
    check("wnd_clamp_pres", 64'(bus_if.opt.tcp_opt_pres.wnd_pres), 64'd1);
    check("wnd_clamp_err", 64'(bus_if.opt_err), 64'd0);

    // Unknown kind skipped silently; duplicate MSS, last one wins.
    seg = '{8'h1E, 8'h04, 8'hAA, 8'hBB, 8'h02, 8'h04, 8'h00, 8'h01, 8'h02, 8'h04, 8'h00, 8'h02};
    hdr(6'd12);
    send("dup", -1, 0, 1'b1);
    exp_opt = '0;
    exp_opt.tcp_opt_mss.mss       = 16'h0002;
    exp_opt.tcp_opt_mss.mss_pres  = 1'b1;
    exp_opt.tcp_opt_pres.mss_pres = 1'b1;
    check_opt("dup_opt", bus_if.opt, exp_opt);
    check("dup_err", 64'(bus_if.opt_err), 64'd0);

    // Option length exceeding remaining bytes: error, nothing applied.
    seg = '{8'h02, 8'h04, 8'h05};
    hdr(6'd3);
    send("trunc", -1, 0, 1'b1);
    check("trunc_err", 64'(bus_if.opt_err), 64'd1);
    check_opt("trunc_opt", bus_if.opt, tcp_opt_t'('0));

    // hdr_val mid-option aborts the segment; the restarted one completes.
    seg = '{8'h02, 8'h04, 8'h05};
    hdr(6'd4);
    send("abort", -1, 0, 1'b0);
    seg = '{8'h02, 8'h04, 8'h05, 8'hDC};
    hdr(6'd4);
    send("restart", -1, 0, 1'b1);
    check("restart_mss", 64'(bus_if.opt.tcp_opt_mss.mss), 64'h05DC);
    check("restart_err", 64'(bus_if.opt_err), 64'd0);

    // Reset in the middle of a timestamp option clears outputs immediately.
    seg = '{8'h02, 8'h04, 8'h05, 8'hDC, 8'h08, 8'h0A, 8'h11, 8'h22};
    hdr(6'd16);
    send("pre_rst", -1, 0, 1'b0);
    check("pre_rst_mss", 64'(bus_if.opt.tcp_opt_mss.mss), 64'h05DC);
    rst_n = 1'b0;
    #2;
    check_opt("mid_rst_opt", bus_if.opt, tcp_opt_t'('0));
    check("mid_rst_val", 64'(bus_if.opt_val), 64'd0);
    check("mid_rst_err", 64'(bus_if.opt_err), 64'd0);
    tick();
    rst_n = 1'b1;
    seg = '{8'h33, 8'h44, 8'h02, 8'h04};
    send("stray", -1, 0, 1'b0);
    check_opt("stray_opt", bus_if.opt, tcp_opt_t'('0));
    hdr(6'd0);
    check("post_rst_val", 64'(bus_if.opt_val), 64'd1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tcp_vlg_opt_parse.md
TCP_VLG_OPT_PARSE -- requirements
Module: tcp_vlg_opt_parse

Interface
REQ-001 SHALL have parameter SACK_BLOCKS, default 4, number of SACK blocks captured (1..4).
REQ-002 SHALL have one clock and an asynchronous active-low reset; no other clock or reset.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 hdr_val  input  1  one-cycle pulse: TCP fixed header parsed, options bytes follow.
REQ-006 opt_len  input  6  option bytes in segment, (tcp_offset-5)*4, sampled with hdr_val, legal 0..40.
REQ-007 rx_dat  input  8  option byte stream, first byte follows hdr_val.
REQ-008 rx_val  input  1  rx_dat valid; low cycles stall parsing.
REQ-009 opt  output  tcp_opt_t  parsed options, registered, stable from opt_val until next hdr_val.
REQ-010 opt_val  output  1  one-cycle pulse: opt complete.
REQ-011 opt_err  output  1  malformed options flag, valid with opt_val.

Function
REQ-012 SHALL implement FSM states IDLE, KIND, LEN, DATA, SKIP, DONE.
REQ-013 hdr_val in any state: clear opt, opt_err, byte counters; load remaining=opt_len; go KIND, or DONE if opt_len=0 (aborts any parse in progress).
REQ-014 Every accepted byte (rx_val=1, state KIND/LEN/DATA/SKIP) decrements remaining; no byte consumed while rx_val=0.
REQ-015 KIND: kind 0 (END) -> SKIP rest; kind 1 (NOP) -> stay KIND; other kinds latch kind -> LEN.
REQ-016 LEN: len<2 or len-2 > remaining-after-this-byte -> opt_err=1, SKIP; len=2 with no data -> apply option (SACK_PERM) and return KIND.
REQ-017 DATA: capture len-2 bytes big-endian into the field for the latched kind, then return KIND.
REQ-018 Kind 2 MSS: len SHALL equal 4; writes tcp_opt_mss.mss, mss_pres and tcp_opt_pres.mss_pres.
REQ-019 Kind 3 window scale: len SHALL equal 3; wnd = min(byte,14) (TCP_MAX_WIN_SCALE); sets wnd_pres both places.
REQ-020 Kind 4 SACK permitted: len SHALL equal 2; sets sack_perm and sack_perm_pres.
REQ-021 Kind 5 SACK: len SHALL be 2+8n, n=1..4; block i left then right, 32-bit each; block_pres[i]=1 for i<min(n,SACK_BLOCKS); excess blocks skipped; sets sack_pres.
REQ-022 Kind 8 timestamp: len SHALL equal 10; first 4 data bytes -> snd (TSval), next 4 -> rec (TSecr); sets timestamp_pres.
REQ-023 Known kind with wrong len: opt_err=1, option bytes skipped, field and pres flags unchanged, parsing continues at next kind.
REQ-024 Unknown kind with legal len: skip len-2 bytes silently, no error.
REQ-025 When remaining reaches 0 in any state: go DONE; if state was LEN or DATA mid-option -> opt_err=1 and partial option discarded.
REQ-026 DONE: opt_val=1 for exactly one cycle, next state IDLE; latency = 1 cycle after the last accepted byte (or after hdr_val when opt_len=0).
REQ-027 Duplicate option of the same kind: last occurrence wins.
REQ-028 Bytes arriving in IDLE/DONE SHALL be ignored.

Reset
REQ-029 On rst_n low: state IDLE, opt all zeros, opt_val=0, opt_err=0, counters 0, asynchronously.
REQ-030 Reset deassertion mid-segment: block waits in IDLE for next hdr_val; stray bytes ignored.

Verification
REQ-031 hdr_val opt_len=0 -> opt_val at next cycle, opt=0, opt_err=0.
REQ-032 SYN options 02 04 05 B4 01 03 03 07 04 02 00 00 (len 12) -> mss=0x05B4, wnd=7, sack_perm=1, pres mss/wnd/sack_perm=1, opt_err=0, opt_val 1 cycle after last byte.
REQ-033 01 01 08 0A 11 22 33 44 55 66 77 88 with rx_val low 3 cycles mid-stream -> snd=0x11223344, rec=0x55667788, timestamp_pres=1, opt_val delayed by 3 cycles.
REQ-034 01 01 05 12 then 16 data bytes (blocks 0x00000100/0x00000200, 0x00000300/0x00000400), len 20 -> block_pres=1100, left/right match, sack_pres=1.
REQ-035 03 04 0E 00 (wnd len 4) -> opt_err=1, wnd_pres=0; 03 03 20 00 -> wnd=14, opt_err=0.
REQ-036 02 04 05 (opt_len=4, 02 04 05 00 truncated by END not present: len claims 4, 3rd byte then hdr_val) -> parse aborted, restarted, no opt_val for first segment; reset asserted mid-DATA -> all outputs zero immediately.
